serial_mag_cmp: RTL and testbench

- Multi-cycle unsigned magnitude comparator for WIDTH-bit words.
- Scans 2-bit digit pairs MSB-first, one digit pair per clock, and produces registered agtb/aeqb flags with a one-cycle done pulse.
- Sits directly upstream of the consumers of the a>b decision.
- Built around a combinational 2-bit digit comparator, instantiated once and reused every cycle.

---
 rtl/serial_mag_cmp_pkg.sv | 12 +
 rtl/digit_cmp2.sv | 12 +
 rtl/serial_mag_cmp.sv | 117 +++++++++++
 tb/tb_serial_mag_cmp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_cmp_pkg.sv
// rtl/serial_mag_cmp_pkg.sv - shared state encoding and digit width for serial_mag_cmp
package serial_mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIGIT_W = 2;

endpackage

// File: rtl/digit_cmp2.sv
// rtl/digit_cmp2.sv - combinational 2-bit unsigned digit comparator
module digit_cmp2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       gt,
    output logic       eq
);

    assign gt = (x[1] & ~y[1]) | (~y[1] & ~y[0] & x[0]) | (x[1] & x[0] & ~y[0]);
    assign eq = (x == y);

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - multi-cycle MSB-first unsigned magnitude comparator
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("serial_mag_cmp: WIDTH must be even and >= 2");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gt_acc_q, gt_acc_d;
    logic               lt_acc_q, lt_acc_d;
    logic               agtb_q, agtb_d;
    logic               aeqb_q, aeqb_d;

    logic               dig_gt, dig_eq;
    logic               gt_next, lt_next, decided;

    digit_cmp2 u_digit_cmp2 (
        .x  (sa_q[WIDTH-1 -: DIGIT_W]),
        .y  (sb_q[WIDTH-1 -: DIGIT_W]),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    // The first differing digit decides; later digits cannot override it.
    assign decided = gt_acc_q | lt_acc_q;
    assign gt_next = gt_acc_q | (~decided & dig_gt);
    assign lt_next = lt_acc_q | (~decided & ~dig_gt & ~dig_eq);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        gt_acc_d = gt_acc_q;
        lt_acc_d = lt_acc_q;
        agtb_d   = agtb_q;
        aeqb_d   = aeqb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    sa_d     = a;
                    sb_d     = b;
                    cnt_d    = '0;
                    gt_acc_d = 1'b0;
                    lt_acc_d = 1'b0;
                end
            end
            RUN: begin
                sa_d     = sa_q << DIGIT_W;
                sb_d     = sb_q << DIGIT_W;
                cnt_d    = cnt_q + 1'b1;
                gt_acc_d = gt_next;
                lt_acc_d = lt_next;
                if (cnt_q == CNT_W'(DIGITS - 1)) begin
                    state_d = DONE;
                    agtb_d  = gt_next;
                    aeqb_d  = ~gt_next & ~lt_next;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            gt_acc_q <= 1'b0;
            lt_acc_q <= 1'b0;
            agtb_q   <= 1'b0;
            aeqb_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            gt_acc_q <= gt_acc_d;
            lt_acc_q <= lt_acc_d;
            agtb_q   <= agtb_d;
            aeqb_q   <= aeqb_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign agtb  = agtb_q;
    assign aeqb  = aeqb_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - scoreboard bench for serial_mag_cmp against an arithmetic reference
module tb_serial_mag_cmp;

    localparam int WIDTH  = 8;
    localparam int DIGITS = WIDTH / 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic             agtb;
    logic             aeqb;

    serial_mag_cmp #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .agtb  (agtb),
        .aeqb  (aeqb)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               gt;
        bit               eq;
        int               due;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rst_edge = 1'b0;
    bit   last_gt  = 1'b0;
    bit   last_eq  = 1'b0;
    int   last_accept = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      = cyc + 1;
        rst_edge = reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset values, flag stability, and scoreboard pop on each done pulse.
    always @(negedge clk) begin
        check("state_onehot", 32'(ready) + 32'(busy) + 32'(done), 32'd1);
        check("flags_exclusive", 32'(agtb & aeqb), 32'd0);
        if (rst_edge) begin
            check("rst_ready", 32'(ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_agtb", 32'(agtb), 32'd0);
            check("rst_aeqb", 32'(aeqb), 32'd0);
            sb_q.delete();
            last_gt = 1'b0;
            last_eq = 1'b0;
        end else if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("agtb a=%02h b=%02h", e.a, e.b), 32'(agtb), 32'(e.gt));
                check($sformatf("aeqb a=%02h b=%02h", e.a, e.b), 32'(aeqb), 32'(e.eq));
                check("done_latency", 32'(cyc), 32'(e.due));
            end
            last_gt = agtb;
            last_eq = aeqb;
        end else begin
            check("flags_hold", {30'd0, agtb, aeqb}, {30'd0, last_gt, last_eq});
            if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                check("missing_done", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
        end
    end

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int acc_edge);
        exp_t e;
        e.a   = x;
        e.b   = y;
        e.gt  = (int'(x) > int'(y));
        e.eq  = (int'(x) == int'(y));
        e.due = acc_edge + DIGITS;
        return e;
    endfunction

    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input bit scramble, input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sbv);
        @(negedge clk);
        wait_ready();
        start = 1'b1;
        a = x;
        b = y;
        sb_q.push_back(model(x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            a = sa;
            b = sbv;
        end
        @(negedge clk);
        wait_ready();
    endtask

    task automatic continuous(input int n);
        int got = 0;
        int guard = 0;
        last_accept = -1;
        while (got < n && guard < 200) begin
            @(negedge clk);
            guard++;
            start = 1'b1;
            a = (got % 2 == 0) ? 8'hC3 : 8'h5A;
            b = (got % 2 == 0) ? 8'h5A : 8'hC3;
            if (ready) begin
                sb_q.push_back(model(a, b, cyc + 1));
                if (last_accept >= 0) check("accept_interval", 32'(cyc + 1 - last_accept), 32'(DIGITS + 2));
                last_accept = cyc + 1;
                got++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        wait_ready();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        do_cmp(8'hA5, 8'hA4, 1'b0, '0, '0);
        do_cmp(8'h3C, 8'h3C, 1'b0, '0, '0);
        do_cmp(8'h7F, 8'h80, 1'b0, '0, '0);
        do_cmp(8'h10, 8'h20, 1'b1, 8'hFF, 8'h20);
        do_cmp(8'hFF, 8'h00, 1'b1, 8'h00, 8'hFF);

        continuous(5);

        // Reset asserted during the second RUN cycle.
        @(negedge clk);
        wait_ready();
        start = 1'b1;
        a = 8'h9E;
        b = 8'h9F;
        sb_q.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);
        do_cmp(8'h9E, 8'h9F, 1'b0, '0, '0);

        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] x, y;
            x = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: y = WIDTH'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmp(x, y, $urandom_range(0, 1) == 1, WIDTH'($urandom), WIDTH'($urandom));
        end

        for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
        if (sb_q.size() != 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
